// File: rtl/fetch_predict_stage_pkg.sv
// Shared definitions for the fetch/predict stage: widths, opcode field
// values, 2-bit branch counter states and small helper functions.
package fetch_predict_stage_pkg;

  localparam int DBITS = 32;

  // Top nibble of the instruction word selects the instruction class.
  localparam logic [3:0] OP_ALU    = 4'b0000;
  localparam logic [3:0] OP_ALUI   = 4'b0001;
  localparam logic [3:0] BR_OPCODE = 4'b0010;
  localparam logic [3:0] OP_JAL    = 4'b0011;
  localparam logic [3:0] OP_LOAD   = 4'b0100;
  localparam logic [3:0] OP_STORE  = 4'b0101;

  // Saturating counter states; the MSB doubles as the taken prediction.
  typedef enum logic [1:0] {
    SN = 2'b00,
    WN = 2'b01,
    WT = 2'b10,
    ST = 2'b11
  } cnt_state_t;

  // Word-aligned branch displacement: sign-extended imm16 scaled by 4.
  function automatic logic [31:0] imm_offset(input logic [31:0] inst);
    return {{14{inst[15]}}, inst[15:0], 2'b00};
  endfunction

  // One training step of a 2-bit counter, saturating at both ends.
  function automatic cnt_state_t train_cnt(input cnt_state_t cur, input logic taken);
    cnt_state_t nxt;
    case (cur)
      SN:      nxt = taken ? WN : SN;
      WN:      nxt = taken ? WT : SN;
      WT:      nxt = taken ? ST : WN;
      ST:      nxt = taken ? ST : WT;
      default: nxt = WN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_predict_stage_bht_2bit.sv
// Direct-mapped table of 2-bit saturating branch counters.
// Combinational read port for the fetch PC, one synchronous training port.
module bht_2bit
  import fetch_predict_stage_pkg::*;
#(
  parameter int BHT_IDX = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BHT_IDX-1:0] rd_idx,
  output cnt_state_t         rd_cnt,
  input  logic               upd_en,
  input  logic [BHT_IDX-1:0] upd_idx,
  input  logic               upd_taken
);

  localparam int ENTRIES = 1 << BHT_IDX;

  cnt_state_t cnt_r [ENTRIES];

  // Read returns the stored value; a same-cycle update is not bypassed.
  assign rd_cnt = cnt_r[rd_idx];

  // Reset every counter to weakly-not-taken; train the addressed entry on update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_r[i] <= WN;
      end
    end else if (upd_en) begin
      cnt_r[upd_idx] <= train_cnt(cnt_r[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/fetch_predict_stage.sv
// Instruction-fetch stage: PC register, PC+4 and branch-target adders,
// BHT-driven prediction and the next-PC priority mux feeding IF/ID.
module fetch_predict_stage
  import fetch_predict_stage_pkg::*;
#(
  parameter int               DBITS     = fetch_predict_stage_pkg::DBITS,
  parameter int               BHT_IDX   = 6,
  parameter logic [DBITS-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [3:0]       BR_OPCODE = fetch_predict_stage_pkg::BR_OPCODE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [DBITS-1:0] redirect_pc,
  input  logic             upd_valid,
  input  logic [DBITS-1:0] upd_pc,
  input  logic             upd_taken,
  output logic [DBITS-1:0] imem_addr,
  input  logic [DBITS-1:0] imem_data,
  output logic [DBITS-1:0] pcIncremented,
  output logic [DBITS-1:0] instWord,
  output logic [DBITS-1:0] brBaseOffset,
  output logic             prediction,
  output logic             flush
);

  localparam logic [DBITS-1:0] PC_STEP = 32'd4;

  logic [DBITS-1:0]   pc_r;
  logic [DBITS-1:0]   pc_next_s;
  logic [DBITS-1:0]   pc_inc_s;
  logic [DBITS-1:0]   br_target_s;
  logic [BHT_IDX-1:0] rd_idx_s;
  logic [BHT_IDX-1:0] upd_idx_s;
  cnt_state_t         rd_cnt_s;
  logic               is_branch_s;
  logic               predict_s;

  // Both adders wrap modulo 2^DBITS without any flagging.
  assign pc_inc_s    = pc_r + PC_STEP;
  assign br_target_s = pc_inc_s + imm_offset(imem_data);
  assign is_branch_s = (imem_data[31:28] == BR_OPCODE);
  assign rd_idx_s    = pc_r[BHT_IDX+1:2];
  assign upd_idx_s   = upd_pc[BHT_IDX+1:2];
  assign predict_s   = is_branch_s & rd_cnt_s[1];

  assign imem_addr     = pc_r;
  assign pcIncremented = pc_inc_s;
  assign instWord      = imem_data;
  assign brBaseOffset  = br_target_s;
  assign prediction    = predict_s;
  assign flush         = redirect_valid;

  bht_2bit #(
    .BHT_IDX (BHT_IDX)
  ) u_bht (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (rd_idx_s),
    .rd_cnt    (rd_cnt_s),
    .upd_en    (upd_valid),
    .upd_idx   (upd_idx_s),
    .upd_taken (upd_taken)
  );

  // Next-PC priority: EX redirect beats stall, stall beats prediction.
  always_comb begin
    pc_next_s = pc_inc_s;
    if (redirect_valid) begin
      pc_next_s = redirect_pc;
    end else if (stall) begin
      pc_next_s = pc_r;
    end else if (predict_s) begin
      pc_next_s = br_target_s;
    end else begin
      pc_next_s = pc_inc_s;
    end
  end

  // PC register, forced to the reset vector while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

endmodule

// File: tb/tb_fetch_predict_stage.sv
// Directed bench for fetch_predict_stage: a table of per-cycle vectors
// followed by hand-written stall, wrap and asynchronous-reset sequences.
module tb_fetch_predict_stage;

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] dat;
    logic [31:0] ea;
    logic [31:0] ei;
    logic [31:0] et;
    logic        ep;
    logic        ef;
  } vec_t;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] BR3 = 32'h2000_0003;
  localparam logic [31:0] ALN = 32'h1000_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect_valid, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, imem_data;
  logic [31:0] imem_addr, pcIncremented, instWord, brBaseOffset;
  logic        prediction, flush;

  int total = 0;
  int bad   = 0;
  vec_t vq[$];

  fetch_predict_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .pcIncremented  (pcIncremented),
    .instWord       (instWord),
    .brBaseOffset   (brBaseOffset),
    .prediction     (prediction),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rpc,
                              input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] dat, input logic [31:0] ea,
                              input logic [31:0] ei, input logic [31:0] et,
                              input logic ep, input logic ef);
    vec_t v;
    v.st = st; v.rv = rv; v.rpc = rpc; v.uv = uv; v.upc = upc; v.ut = ut;
    v.dat = dat; v.ea = ea; v.ei = ei; v.et = et; v.ep = ep; v.ef = ef;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive at the negedge, check combinational outputs 1 ns later, then let one posedge pass.
  task automatic apply(input vec_t v, input string tag);
    stall = v.st; redirect_valid = v.rv; redirect_pc = v.rpc;
    upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut; imem_data = v.dat;
    #1;
    chk({tag, ".addr"}, imem_addr, v.ea);
    chk({tag, ".inc"},  pcIncremented, v.ei);
    chk({tag, ".tgt"},  brBaseOffset, v.et);
    chk({tag, ".pred"}, {31'd0, prediction}, {31'd0, v.ep});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, v.ef});
    chk({tag, ".inst"}, instWord, v.dat);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; imem_data = NOP;

    //          st    rv    rpc           uv    upc        ut    data  addr          inc           tgt           pred  flush
    vq.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, NOP, 32'h00,       32'h04,       32'h04,       1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, NOP, 32'h04,       32'h08,       32'h08,       1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, NOP, 32'h08,       32'h0C,       32'h0C,       1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, NOP, 32'h0C,       32'h10,       32'h10,       1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, BR3, 32'h10,       32'h14,       32'h20,       1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h10, 1'b1, NOP, 32'h14,       32'h18,       32'h18,       1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h10, 1'b1, NOP, 32'h18,       32'h1C,       32'h1C,       1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 32'h10,       1'b0, 32'h0,  1'b0, NOP, 32'h1C,       32'h20,       32'h20,       1'b0, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h10, 1'b1, BR3, 32'h10,       32'h14,       32'h20,       1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 32'h10,       1'b0, 32'h0,  1'b0, NOP, 32'h20,       32'h24,       32'h24,       1'b0, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, BR3, 32'h10,       32'h14,       32'h20,       1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h10, 1'b0, NOP, 32'h20,       32'h24,       32'h24,       1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h10, 1'b0, NOP, 32'h24,       32'h28,       32'h28,       1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h10, 1'b0, NOP, 32'h28,       32'h2C,       32'h2C,       1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 32'h10,       1'b1, 32'h10, 1'b0, NOP, 32'h2C,       32'h30,       32'h30,       1'b0, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h10, 1'b1, BR3, 32'h10,       32'h14,       32'h20,       1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 32'h10,       1'b0, 32'h0,  1'b0, NOP, 32'h14,       32'h18,       32'h18,       1'b0, 1'b1));
    vq.push_back(mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h10, 1'b1, BR3, 32'h10,       32'h14,       32'h20,       1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, BR3, 32'h10,       32'h14,       32'h20,       1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, ALN, 32'h20,       32'h24,       32'h20,       1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, NOP, 32'h24,       32'h28,       32'h28,       1'b0, 1'b0));

    // Reset held: outputs reflect the reset vector and a non-predicting table.
    @(negedge clk);
    @(negedge clk);
    imem_data = BR3;
    #1;
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.inc",  pcIncremented, 32'h4);
    chk("rst.pred", {31'd0, prediction}, 32'h0);
    @(negedge clk);
    chk("rst.hold", imem_addr, 32'h0);
    reset = 1'b1;

    foreach (vq[i]) begin
      apply(vq[i], $sformatf("v%0d", i));
    end

    // Stall holds PC at 0x8, then a redirect overrides the stall.
    apply(mk(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, NOP, 32'h28, 32'h2C, 32'h2C, 1'b0, 1'b1), "s0");
    apply(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, NOP, 32'h08, 32'h0C, 32'h0C, 1'b0, 1'b0), "s1");
    apply(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, NOP, 32'h08, 32'h0C, 32'h0C, 1'b0, 1'b0), "s2");
    apply(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, NOP, 32'h08, 32'h0C, 32'h0C, 1'b0, 1'b0), "s3");
    apply(mk(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, NOP, 32'h08, 32'h0C, 32'h0C, 1'b0, 1'b1), "s4");

    // PC wraps from the top of the address space back to zero.
    apply(mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, NOP, 32'h40, 32'h44, 32'h44, 1'b0, 1'b1), "w0");
    apply(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, NOP, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0), "w1");
    apply(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4, 32'h4, 1'b0, 1'b0), "w2");

    // Asynchronous reset mid-cycle: PC returns to the reset vector without a clock edge.
    chk("ar.pre", imem_addr, 32'h4);
    #2;
    reset = 1'b0;
    #1;
    chk("ar.addr", imem_addr, 32'h0);
    chk("ar.inc",  pcIncremented, 32'h4);
    @(negedge clk);
    reset = 1'b1;

    // Counter at 0x10 was weakly-taken before reset; it must now be weakly-not-taken.
    apply(mk(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4, 32'h4, 1'b0, 1'b1), "a0");
    apply(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, BR3, 32'h10, 32'h14, 32'h20, 1'b0, 1'b0), "a1");
    apply(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, NOP, 32'h14, 32'h18, 32'h18, 1'b0, 1'b0), "a2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
